// File: rtl/gshare_predictor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gshare_predictor_pkg                                            |
// | Brief    : Shared default geometry for the gshare direction/target predictor|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package gshare_predictor_pkg;

  localparam int BP_DAT_W     = 32;
  localparam int BP_IDX_W     = 6;
  localparam int BP_CNT_W     = 2;
  localparam int BP_HIST_W    = 6;
  localparam int BP_BTB_IDX_W = 4;
  localparam int BP_TAG_W     = 8;
  localparam int BP_MODE      = 1;

endpackage
`default_nettype wire

// File: rtl/bp_btb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bp_btb                                                          |
// | Brief    : Direct-mapped tagged BTB with lookup, write and clear ports     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module bp_btb
  import gshare_predictor_pkg::*;
#(
  parameter int BTB_IDX_W = BP_BTB_IDX_W,
  parameter int TAG_W     = BP_TAG_W,
  parameter int DAT_W     = BP_DAT_W
) (
  input  logic                 clk,
  input  logic [DAT_W-1:0]     i_lk_pc,
  output logic                 o_hit,
  output logic [DAT_W-1:0]     o_tgt,
  input  logic                 i_wr_en,
  input  logic [DAT_W-1:0]     i_wr_pc,
  input  logic [DAT_W-1:0]     i_wr_tgt,
  input  logic                 i_clr_en,
  input  logic [BTB_IDX_W-1:0] i_clr_idx
);

  localparam int c_depth = 2**BTB_IDX_W;

  logic                 r_vld [c_depth];
  logic [TAG_W-1:0]     r_tag [c_depth];
  logic [DAT_W-1:0]     r_tgt [c_depth];

  logic [BTB_IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0]     w_lk_tag;
  logic [BTB_IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0]     w_wr_tag;
  logic                 w_unused;

  assign w_lk_idx = i_lk_pc[BTB_IDX_W+1:2];
  assign w_lk_tag = i_lk_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign w_wr_idx = i_wr_pc[BTB_IDX_W+1:2];
  assign w_wr_tag = i_wr_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign w_unused = ^{i_lk_pc, i_wr_pc};

  assign o_hit = r_vld[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_tgt = r_tgt[w_lk_idx];

  // Arrays carry no reset; validity is cleared entry by entry from the init sweep.
  always_ff @(posedge clk) begin
    if (i_clr_en) begin
      r_vld[i_clr_idx] <= 1'b0;
    end else if (i_wr_en) begin
      r_vld[w_wr_idx] <= 1'b1;
      r_tag[w_wr_idx] <= w_wr_tag;
      r_tgt[w_wr_idx] <= i_wr_tgt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gshare_predictor                                                |
// | Brief    : Gshare/bimodal PHT with speculative GHR, repair and tagged BTB  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int IDX_W     = BP_IDX_W,
  parameter int CNT_W     = BP_CNT_W,
  parameter int HIST_W    = BP_HIST_W,
  parameter int BTB_IDX_W = BP_BTB_IDX_W,
  parameter int TAG_W     = BP_TAG_W,
  parameter int MODE      = BP_MODE,
  parameter int DAT_W     = BP_DAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              if_rdy_o,
  input  logic              if_req_i,
  input  logic [DAT_W-1:0]  if_pc_i,
  output logic              if_br_o,
  output logic              if_hit_o,
  output logic [DAT_W-1:0]  if_tgt_o,
  output logic [HIST_W-1:0] if_ghr_o,
  input  logic              if_en_i,
  input  logic              if_abr_i,
  input  logic [DAT_W-1:0]  if_tpc_i,
  input  logic [DAT_W-1:0]  if_ttgt_i,
  input  logic [HIST_W-1:0] if_tghr_i,
  input  logic              if_mis_i
);

  localparam int               c_depth     = 2**IDX_W;
  localparam logic [0:0]       c_st_init   = 1'b0;
  localparam logic [0:0]       c_st_run    = 1'b1;
  localparam logic [CNT_W-1:0] c_weak_tkn  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] c_ptr_last  = {IDX_W{1'b1}};

  generate
    if (HIST_W > IDX_W) begin : g_chk_hist
      $error("gshare_predictor: HIST_W must not exceed IDX_W");
    end
    if (BTB_IDX_W > IDX_W) begin : g_chk_btb
      $error("gshare_predictor: BTB_IDX_W must not exceed IDX_W");
    end
  endgenerate

  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [HIST_W-1:0] r_ghr;
  logic              r_rdy;
  logic [CNT_W-1:0]  r_pht [c_depth];

  logic              w_run;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_uidx;
  logic [CNT_W-1:0]  w_ctr_old;
  logic [CNT_W-1:0]  w_ctr_new;
  logic              w_btb_hit;
  logic [DAT_W-1:0]  w_btb_tgt;
  logic              w_clr_range;
  logic              w_clr_en;
  logic              w_btb_wr;

  assign w_run  = (r_state == c_st_run);
  assign w_idx  = if_pc_i[IDX_W+1:2]  ^ ((MODE != 0) ? IDX_W'(r_ghr)     : '0);
  assign w_uidx = if_tpc_i[IDX_W+1:2] ^ ((MODE != 0) ? IDX_W'(if_tghr_i) : '0);

  assign w_ctr_old = r_pht[w_uidx];

  always_comb begin
    w_ctr_new = w_ctr_old;
    if (if_abr_i) begin
      if (w_ctr_old != c_cnt_max) w_ctr_new = w_ctr_old + CNT_W'(1);
    end else begin
      if (w_ctr_old != '0) w_ctr_new = w_ctr_old - CNT_W'(1);
    end
  end

  // The sweep pointer spans the PHT; only its low part addresses the BTB.
  generate
    if (BTB_IDX_W == IDX_W) begin : g_clr_all
      assign w_clr_range = 1'b1;
    end else begin : g_clr_low
      assign w_clr_range = ~|r_ptr[IDX_W-1:BTB_IDX_W];
    end
  endgenerate

  assign w_clr_en = en && !w_run && w_clr_range;
  assign w_btb_wr = en && w_run && if_en_i && if_abr_i;

  bp_btb #(
    .BTB_IDX_W (BTB_IDX_W),
    .TAG_W     (TAG_W),
    .DAT_W     (DAT_W)
  ) u_btb (
    .clk       (clk),
    .i_lk_pc   (if_pc_i),
    .o_hit     (w_btb_hit),
    .o_tgt     (w_btb_tgt),
    .i_wr_en   (w_btb_wr),
    .i_wr_pc   (if_tpc_i),
    .i_wr_tgt  (if_ttgt_i),
    .i_clr_en  (w_clr_en),
    .i_clr_idx (r_ptr[BTB_IDX_W-1:0])
  );

  assign if_rdy_o = r_rdy;
  assign if_br_o  = r_rdy && r_pht[w_idx][CNT_W-1];
  assign if_hit_o = r_rdy && w_btb_hit;
  assign if_tgt_o = r_rdy ? w_btb_tgt : '0;
  assign if_ghr_o = r_ghr;

  always_ff @(posedge clk) begin
    if (en) begin
      if (!w_run) begin
        r_pht[r_ptr] <= c_weak_tkn;
      end else if (if_en_i) begin
        r_pht[w_uidx] <= w_ctr_new;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_init;
      r_ptr   <= '0;
      r_ghr   <= '0;
      r_rdy   <= 1'b0;
    end else if (en) begin
      case (r_state)
        c_st_init: begin
          r_ptr <= r_ptr + IDX_W'(1);
          if (r_ptr == c_ptr_last) begin
            r_state <= c_st_run;
            r_rdy   <= 1'b1;
          end
        end
        default: begin
          // A resolved mispredict rebuilds history from its checkpoint and wins over speculation.
          if (if_en_i && if_mis_i) begin
            r_ghr <= {if_tghr_i[HIST_W-2:0], if_abr_i};
          end else if (if_req_i) begin
            r_ghr <= {r_ghr[HIST_W-2:0], if_br_o};
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gshare_predictor                                             |
// | Brief    : Directed checks of a bimodal and a gshare instance side by side |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        if_req_i;
  logic [31:0] if_pc_i;
  logic        if_en_i;
  logic        if_abr_i;
  logic [31:0] if_tpc_i;
  logic [31:0] if_ttgt_i;
  logic [5:0]  if_tghr_i;
  logic        if_mis_i;

  logic        b_rdy, b_br, b_hit;
  logic [31:0] b_tgt;
  logic [5:0]  b_ghr;
  logic        g_rdy, g_br, g_hit;
  logic [31:0] g_tgt;
  logic [5:0]  g_ghr;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  gshare_predictor #(.MODE(0)) u_bim (
    .clk(clk), .rst(rst), .en(en), .if_rdy_o(b_rdy), .if_req_i(if_req_i),
    .if_pc_i(if_pc_i), .if_br_o(b_br), .if_hit_o(b_hit), .if_tgt_o(b_tgt),
    .if_ghr_o(b_ghr), .if_en_i(if_en_i), .if_abr_i(if_abr_i), .if_tpc_i(if_tpc_i),
    .if_ttgt_i(if_ttgt_i), .if_tghr_i(if_tghr_i), .if_mis_i(if_mis_i)
  );

  gshare_predictor #(.MODE(1)) u_gsh (
    .clk(clk), .rst(rst), .en(en), .if_rdy_o(g_rdy), .if_req_i(if_req_i),
    .if_pc_i(if_pc_i), .if_br_o(g_br), .if_hit_o(g_hit), .if_tgt_o(g_tgt),
    .if_ghr_o(g_ghr), .if_en_i(if_en_i), .if_abr_i(if_abr_i), .if_tpc_i(if_tpc_i),
    .if_ttgt_i(if_ttgt_i), .if_tghr_i(if_tghr_i), .if_mis_i(if_mis_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] tpc, input logic [31:0] tgt, input logic abr,
                     input logic [5:0] tghr, input logic mis);
    if_en_i = 1'b1; if_tpc_i = tpc; if_ttgt_i = tgt; if_abr_i = abr;
    if_tghr_i = tghr; if_mis_i = mis;
    tick();
    if_en_i = 1'b0; if_abr_i = 1'b0; if_mis_i = 1'b0;
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 0;
    while (!(b_rdy && g_rdy) && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; if_req_i = 1'b0; if_pc_i = '0; if_en_i = 1'b0;
    if_abr_i = 1'b0; if_tpc_i = '0; if_ttgt_i = '0; if_tghr_i = '0; if_mis_i = 1'b0;
    #12 rst = 1'b0;
    #1;
    // Reset state and init sweep length
    chk("rst_rdy", b_rdy, 0);
    chk("rst_br",  b_br,  0);
    chk("rst_hit", b_hit, 0);
    chk("rst_tgt", b_tgt, 0);
    chk("rst_ghr", g_ghr, 0);
    wait_rdy(n);
    chk("init_cycles", n, 64);
    if_pc_i = 32'h40; #1;
    chk("init_br_bim", b_br, 1);
    chk("init_br_gsh", g_br, 1);
    chk("init_hit", b_hit, 0);

    // Counter saturation on pc 0x40 (idx 16)
    repeat (3) upd(32'h40, 32'h80, 1'b1, 6'd0, 1'b0);
    #1 chk("sat_hi_br", b_br, 1);
    upd(32'h40, 32'h80, 1'b0, 6'd0, 1'b0);
    #1 chk("dec_from_max_br", b_br, 1);
    repeat (3) upd(32'h40, 32'h80, 1'b0, 6'd0, 1'b0);
    #1 chk("sat_lo_br", b_br, 0);
    upd(32'h40, 32'h80, 1'b1, 6'd0, 1'b0);
    #1 chk("inc_from_zero_br", b_br, 0);
    upd(32'h40, 32'h80, 1'b1, 6'd0, 1'b0);
    #1 chk("inc_to_two_br", b_br, 1);
    chk("btb_40_hit", b_hit, 1);
    chk("btb_40_tgt", b_tgt, 32'h80);

    // BTB fill, alias and eviction (0x40, 0x100, 0x140 share BTB set 0)
    upd(32'h100, 32'h200, 1'b1, 6'd0, 1'b0);
    if_pc_i = 32'h100; #1;
    chk("btb_hit", b_hit, 1);
    chk("btb_tgt", b_tgt, 32'h200);
    if_pc_i = 32'h140; #1;
    chk("btb_alias_hit", b_hit, 0);
    if_pc_i = 32'h40; #1;
    chk("btb_evict_hit", b_hit, 0);

    // Speculative history then same-cycle repair
    if_pc_i = 32'h80; if_req_i = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("spec_br", g_br, 1);
      tick();
    end
    chk("spec_ghr", g_ghr, 6'b000111);
    upd(32'h80, 32'h0, 1'b0, 6'b000001, 1'b1);
    if_req_i = 1'b0; #1;
    chk("repair_ghr", g_ghr, 6'b000010);

    // Same-cycle predict/update on one PHT entry and one BTB entry
    if_pc_i = 32'hC0; if_en_i = 1'b1; if_tpc_i = 32'hC0; if_abr_i = 1'b0; if_tghr_i = '0;
    #1 chk("bypass_old_br", b_br, 1);
    tick();
    if_en_i = 1'b0;
    #1 chk("bypass_new_br", b_br, 0);
    if_pc_i = 32'h204; if_en_i = 1'b1; if_tpc_i = 32'h204; if_ttgt_i = 32'h300; if_abr_i = 1'b1;
    #1 chk("bypass_old_hit", b_hit, 0);
    tick();
    if_en_i = 1'b0; if_abr_i = 1'b0;
    #1 chk("bypass_new_hit", b_hit, 1);
    chk("bypass_new_tgt", b_tgt, 32'h300);

    // en low freezes everything despite active requests and updates
    en = 1'b0; if_req_i = 1'b1; if_pc_i = 32'h80; if_en_i = 1'b1; if_tpc_i = 32'h80;
    if_ttgt_i = 32'h999; if_abr_i = 1'b1; if_tghr_i = 6'h3F; if_mis_i = 1'b1;
    repeat (5) tick();
    en = 1'b1; if_req_i = 1'b0; if_en_i = 1'b0; if_abr_i = 1'b0; if_mis_i = 1'b0;
    #1;
    chk("hold_ghr", g_ghr, 6'b000010);
    chk("hold_pht_br", b_br, 0);
    chk("hold_btb_hit", g_hit, 0);

    // Reset in the middle of the init sweep
    rst = 1'b1; #1 rst = 1'b0;
    repeat (20) tick();
    chk("midsweep_rdy", b_rdy, 0);
    rst = 1'b1; #1;
    chk("rerst_rdy", g_rdy, 0);
    chk("rerst_ghr", g_ghr, 0);
    rst = 1'b0;
    wait_rdy(n);
    chk("restart_cycles", n, 64);
    if_pc_i = 32'h204; #1;
    chk("cleared_hit", b_hit, 0);
    if_pc_i = 32'h80; #1;
    chk("cleared_br", b_br, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
